// File: rtl/mult_pkg.sv
// Shared definitions for the sequential multiplier: FSM state codes and a width helper.
// No logic of its own, so no latency.
// No flow control of its own.
package mult_pkg;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Ceiling log2, used to size the iteration counter (value >= 2 gives >= 1).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_addsub.sv
// Purely combinational N-bit adder/subtractor: s = x + y, or x - y when sub is high.
// Zero cycles.
// No flow control; it is a combinational leaf.
module mult_addsub #(
    parameter int N = 5
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         sub,
    output logic [N-1:0] s
);

    assign s = sub ? (x - y) : (x + y);

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, one add per cycle.
// done is registered WIDTH+1 edges after the edge that accepts start (edge 1).
// start is accepted only in IDLE or DONE and ignored while busy.
// Optional feature macro: SIGNED_MODE_EN adds the signed_mode port.
module seq_multiplier #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
`ifdef SIGNED_MODE_EN
    input  logic               signed_mode,
`endif
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] res
);
    import mult_pkg::*;

    localparam int CW = clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    cnt;
    logic             sgn;
    logic             sub;
    logic             last;
    logic [WIDTH:0]   addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   acc_nx;
    logic [WIDTH-1:0] mplr_nx;

    assign last = (cnt == CNT_LAST);

`ifdef SIGNED_MODE_EN
    // Signedness is latched with the operands so a mid-op change has no effect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn <= 1'b0;
        end else if (start && (state != ST_RUN)) begin
            sgn <= signed_mode;
        end
    end

    // In signed mode the multiplier MSB carries negative weight, so the last step subtracts.
    assign sub = sgn & last;
`else
    assign sgn = 1'b0;
    assign sub = 1'b0;
`endif

    // Select the partial product for this iteration and form the shifted next state.
    always_comb begin
        addend = '0;
        if (mplr[0]) begin
            addend = sgn ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
        end
        acc_nx  = {sgn & sum[WIDTH], sum[WIDTH:1]};
        mplr_nx = {sum[0], mplr[WIDTH-1:1]};
    end

    mult_addsub #(
        .N(WIDTH + 1)
    ) u_addsub (
        .x   (acc),
        .y   (addend),
        .sub (sub),
        .s   (sum)
    );

    // Control FSM with the acc/mplr shift register, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            res   <= '0;
            a_q   <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        a_q   <= a;
                        mplr  <= b;
                        acc   <= '0;
                        cnt   <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc  <= acc_nx;
                    mplr <= mplr_nx;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        res   <= {acc_nx[WIDTH-1:0], mplr_nx};
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
